intra_scan_seq: RTL and testbench
=================================

Name: intra_scan_seq

Overview:
- Parametrised successor to the fixed intra TU scan FSM.
- For each accepted TU it emits, one per cycle, a walk over 4x4 units (X, Y), plus pre-stage and order tags, to the intra prediction/reconstruction datapath.
- Replaces the enumerated per-size state lists with counters. Supports TU sizes up to 2^MAX_LOG2_TU, optional chroma passes (Cb then Cr, 4:2:0 or 4:2:2), and a start/busy/done handshake with stall.

Parameters:
- MAX_LOG2_TU, 5, largest legal log2 TU size (5 or 6).
- CHROMA, 0, 1 = two chroma passes per TU (cIdx 1, then 2); 0 = one luma pass (cIdx 0).
- CHROMA_422, 0, 1 = each chroma pass covers two vertically stacked square blocks (unit rows doubled); ignored when CHROMA=0.
- XY_W, MAX_LOG2_TU-1, width of X/Y outputs; sized to hold the 4:2:2 doubled row count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request to sequence one TU; sampled only in IDLE.
- tuSize  in  3  log2 TU size (2=4x4 … 6=64x64); latched with start.
- isInter  in  1  1 = skip pre-stages; latched with start.
- bStop  in  1  stall; freezes all state and outputs.
- busy  out  1  high from the cycle after acceptance through the last emitted unit.
- out_valid  out  1  X/Y/preStage/order/cIdx are meaningful.
- X  out  XY_W  unit column.
- Y  out  XY_W  unit row.
- preStage  out  5  pre-stage index 0..P-1; 31 during scan cycles.
- order  out  3  position tag within the pass.
- cIdx  out  2  component of the current pass.
- done  out  1  one-cycle pulse after the final unit of the final pass advances.
- err  out  1  one-cycle pulse when start is seen in IDLE with an illegal tuSize.

Behaviour:
- Reset (rst=1 at a clk edge, in any state, including mid-TU): state=IDLE. busy=0, out_valid=0, X=0, Y=0, preStage=0, order=0, cIdx=0, done=0, err=0. The in-flight TU is discarded.
- Sizing:
  - Nu = 2^(tuSize-2) units per side.
  - Rows R = Nu, or 2*Nu for chroma passes when CHROMA_422=1.
  - Pre-stage count P = (Nu*R)/16 when isInter=0 and Nu*R ≥ 16, else 0.
  - Pass length T = P + Nu*R cycles.
- Legality: tuSize must be in 2..MAX_LOG2_TU. An illegal start gives err=1 for the next cycle, nothing else, and the FSM stays in IDLE.
- States and transitions:
  - IDLE: outputs at reset values. On a legal start, latch tuSize and isInter, set cIdx = CHROMA ? 1 : 0, and go next cycle to PRE if P>0, else SCAN.
  - PRE: out_valid=1, X=Nu-1, Y=R-1, preStage = pre-stage counter. Counter increments per unstalled cycle; at P-1, go to SCAN.
  - SCAN: out_valid=1, preStage=31. Reverse raster: starts at X=Nu-1, Y=R-1. X decrements each unstalled cycle. When X=0, X wraps to Nu-1 and Y decrements. At X=0,Y=0 the pass ends:
    - If CHROMA=1 and cIdx=1: set cIdx=2, reload counters, go to PRE (P>0) or SCAN.
    - Otherwise: go to IDLE, with done=1 for one cycle and busy=0 in that same cycle.
- order, by cycle index k within the pass (0..T-1), highest priority first:
  - 7 if k=T-1
  - 6 if k=T-2 and T≥3
  - 5 if k=T-3 and T≥4
  - 0 if k=0
  - 1 if k=1
  - 2 otherwise
- Stall: while bStop=1 no register changes. Outputs hold, out_valid stays high, done/err pulses extend. start during a stall in IDLE is ignored.
- start while busy is ignored. There is no queueing.
- Latency: the first output is valid exactly one cycle after start is sampled. Back-to-back TUs: start may be asserted in the done cycle and is accepted, because the FSM is in IDLE then.
- All outputs are decoded combinationally from registered state and counters. No combinational path from start or bStop to X/Y.

Test Plan:
- Luma 8x8, isInter=0, CHROMA=0: start tuSize=3 → 4 cycles (X,Y) = (1,1),(0,1),(1,0),(0,0); order 0,6,5… resolved by priority as 0,5,6,7; preStage=31; done one cycle after (0,0).
- Luma 32x32 intra: tuSize=5 → 4 pre-stage cycles (preStage 0..3, X=Y=7), then 64 scan cycles from (7,7) to (0,0); total busy 68 cycles; last three orders 5,6,7. Same with isInter=1 → 64 cycles, no pre-stage.
- CHROMA=1, CHROMA_422=1, tuSize=3 intra: Cb pass has Nu=2, R=4, P=0 (8 cycles, Y 3→0), then Cr pass of 8 cycles with cIdx=2; one done pulse after 16 cycles.
- Stall: assert bStop for 5 cycles mid-scan of 16x16 at (2,1) → outputs hold (2,1) for 6 cycles total, then resume at (1,1); total length 17+5 cycles.
- Illegal and boundary: tuSize=7 (or 6 with MAX_LOG2_TU=5) → err pulse, busy stays 0. start held high across done → next TU starts the cycle after done, with no gap cycle.
- Reset mid-operation: rst at unit (3,2) of a 16x16 pass → next cycle all outputs at reset values. A subsequent start sequences from (3,3) normally.

Source files
------------

// File: rtl/intra_scan_seq.sv
`default_nettype none
// ============================================================================
// Module      : intra_scan_seq
// Description : Counter-based intra TU scan sequencer. For each accepted TU it
//               emits one 4x4 unit per cycle: optional pre-stage cycles, then
//               a reverse raster walk, once for luma or twice (Cb, Cr) for
//               chroma, with start/busy/done handshake and bStop stall.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module intra_scan_seq #(
    parameter int MAX_LOG2_TU = 5,
    parameter int CHROMA      = 0,
    parameter int CHROMA_422  = 0,
    parameter int XY_W        = MAX_LOG2_TU - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      tuSize,
    input  logic            isInter,
    input  logic            bStop,
    output logic            busy,
    output logic            out_valid,
    output logic [XY_W-1:0] X,
    output logic [XY_W-1:0] Y,
    output logic [4:0]      preStage,
    output logic [2:0]      order,
    output logic [1:0]      cIdx,
    output logic            done,
    output logic            err
);

    // Cycle index width: a pass is at most units + units/16 cycles.
    localparam int         c_KW         = 2 * MAX_LOG2_TU;
    localparam int         c_UW         = c_KW + 1;
    localparam logic       c_DBL        = (CHROMA != 0) && (CHROMA_422 != 0);
    localparam logic [1:0] c_FIRST_CIDX = (CHROMA != 0) ? 2'd1 : 2'd0;
    localparam logic [2:0] c_MAX_TU     = 3'(MAX_LOG2_TU);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_PRE  = 2'd1;
    localparam logic [1:0] c_SCAN = 2'd2;

    // Sizing derived from the incoming request; only consumed at acceptance.
    logic [2:0]      w_lgnu;
    logic [2:0]      w_lgr;
    logic [3:0]      w_lgu;
    logic [XY_W-1:0] w_nu_m1;
    logic [XY_W-1:0] w_r_m1;
    logic [c_UW-1:0] w_units;
    logic [c_UW-1:0] w_p;
    logic            w_has_pre;
    logic [c_KW-1:0] w_tm1;
    logic [4:0]      w_pm1;
    logic            w_legal;

    // Registered sequencing state.
    logic [1:0]      r_state;
    logic [XY_W-1:0] r_nu_m1;
    logic [XY_W-1:0] r_r_m1;
    logic [XY_W-1:0] r_x;
    logic [XY_W-1:0] r_y;
    logic [4:0]      r_pre;
    logic [4:0]      r_pm1;
    logic            r_has_pre;
    logic [c_KW-1:0] r_k;
    logic [c_KW-1:0] r_tm1;
    logic [1:0]      r_cidx;
    logic            r_done;
    logic            r_err;

    logic            w_active;

    // Per-request geometry: side, rows, pre-stage count and pass length - 1.
    // Results for illegal tuSize wrap harmlessly; they are never latched.
    always_comb begin
        w_lgnu    = tuSize - 3'd2;
        w_lgr     = w_lgnu + {2'b00, c_DBL};
        w_lgu     = {w_lgnu, 1'b0} + {3'b000, c_DBL};
        w_nu_m1   = (XY_W'(1) << w_lgnu) - XY_W'(1);
        // Modulo arithmetic: a full-width row count wraps to all-ones here.
        w_r_m1    = (XY_W'(1) << w_lgr) - XY_W'(1);
        w_units   = c_UW'(1) << w_lgu;
        w_has_pre = !isInter && (w_lgu >= 4'd4);
        w_p       = w_has_pre ? (w_units >> 4) : '0;
        w_tm1     = c_KW'(w_p + w_units - c_UW'(1));
        w_pm1     = 5'(w_p - c_UW'(1));
        w_legal   = (tuSize >= 3'd2) && (tuSize <= c_MAX_TU);
    end

    // Sequencer: accept a TU, walk pre-stages, reverse raster, repeat for Cr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_nu_m1   <= '0;
            r_r_m1    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_pre     <= '0;
            r_pm1     <= '0;
            r_has_pre <= 1'b0;
            r_k       <= '0;
            r_tm1     <= '0;
            r_cidx    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else if (!bStop) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (w_legal) begin
                            r_nu_m1   <= w_nu_m1;
                            r_r_m1    <= w_r_m1;
                            r_x       <= w_nu_m1;
                            r_y       <= w_r_m1;
                            r_has_pre <= w_has_pre;
                            r_pm1     <= w_pm1;
                            r_tm1     <= w_tm1;
                            r_pre     <= '0;
                            r_k       <= '0;
                            r_cidx    <= c_FIRST_CIDX;
                            r_state   <= w_has_pre ? c_PRE : c_SCAN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_PRE: begin
                    r_k <= r_k + c_KW'(1);
                    if (r_pre == r_pm1) begin
                        r_state <= c_SCAN;
                    end else begin
                        r_pre <= r_pre + 5'd1;
                    end
                end
                c_SCAN: begin
                    if ((r_x == '0) && (r_y == '0)) begin
                        if ((CHROMA != 0) && (r_cidx == 2'd1)) begin
                            r_cidx  <= 2'd2;
                            r_x     <= r_nu_m1;
                            r_y     <= r_r_m1;
                            r_pre   <= '0;
                            r_k     <= '0;
                            r_state <= r_has_pre ? c_PRE : c_SCAN;
                        end else begin
                            r_state <= c_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_k <= r_k + c_KW'(1);
                        if (r_x == '0) begin
                            r_x <= r_nu_m1;
                            r_y <= r_y - XY_W'(1);
                        end else begin
                            r_x <= r_x - XY_W'(1);
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Output decode from registered state; IDLE presents reset values.
    always_comb begin
        w_active  = (r_state != c_IDLE);
        busy      = w_active;
        out_valid = w_active;
        X         = w_active ? r_x : '0;
        Y         = w_active ? r_y : '0;
        cIdx      = w_active ? r_cidx : 2'd0;
        done      = r_done;
        err       = r_err;
        if (r_state == c_PRE) begin
            preStage = r_pre;
        end else if (r_state == c_SCAN) begin
            preStage = 5'd31;
        end else begin
            preStage = 5'd0;
        end
        // Tail tags take priority over the head tags on very short passes.
        if (!w_active) begin
            order = 3'd0;
        end else if (r_k == r_tm1) begin
            order = 3'd7;
        end else if ((r_tm1 >= c_KW'(2)) && (r_k == r_tm1 - c_KW'(1))) begin
            order = 3'd6;
        end else if ((r_tm1 >= c_KW'(3)) && (r_k == r_tm1 - c_KW'(2))) begin
            order = 3'd5;
        end else if (r_k == '0) begin
            order = 3'd0;
        end else if (r_k == c_KW'(1)) begin
            order = 3'd1;
        end else begin
            order = 3'd2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_intra_scan_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_intra_scan_seq
// Description : Scoreboard bench for intra_scan_seq. dut0 is a luma
//               sequencer (MAX_LOG2_TU=5); dut1 is a 4:2:2 chroma sequencer
//               (MAX_LOG2_TU=6). Expected outputs are queued per DUT when a
//               TU is accepted and popped by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intra_scan_seq;

    logic       clk;
    logic       rst;
    logic       bStop;
    logic       isInter;
    logic [2:0] tuSize;
    logic [1:0] start_v;

    logic       w_busy0, w_ov0, w_dn0, w_er0;
    logic [3:0] w_x0, w_y0;
    logic [4:0] w_ps0;
    logic [2:0] w_od0;
    logic [1:0] w_ci0;

    logic       w_busy1, w_ov1, w_dn1, w_er1;
    logic [4:0] w_x1, w_y1;
    logic [4:0] w_ps1;
    logic [2:0] w_od1;
    logic [1:0] w_ci1;

    int n_checks = 0;
    int n_errors = 0;

    // Expected signature: {ov,busy,done,err,X[7:0],Y[7:0],pre[4:0],ord[2:0],cIdx[1:0]}
    logic [29:0] q0[$];
    logic [29:0] q1[$];

    intra_scan_seq #(.MAX_LOG2_TU(5), .CHROMA(0), .CHROMA_422(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .tuSize(tuSize), .isInter(isInter),
        .bStop(bStop), .busy(w_busy0), .out_valid(w_ov0), .X(w_x0), .Y(w_y0),
        .preStage(w_ps0), .order(w_od0), .cIdx(w_ci0), .done(w_dn0), .err(w_er0)
    );

    intra_scan_seq #(.MAX_LOG2_TU(6), .CHROMA(1), .CHROMA_422(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .tuSize(tuSize), .isInter(isInter),
        .bStop(bStop), .busy(w_busy1), .out_valid(w_ov1), .X(w_x1), .Y(w_y1),
        .preStage(w_ps1), .order(w_od1), .cIdx(w_ci1), .done(w_dn1), .err(w_er1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string fmt(input logic [29:0] v);
        return $sformatf("ov=%0b busy=%0b done=%0b err=%0b X=%0d Y=%0d pre=%0d ord=%0d cIdx=%0d",
                         v[29], v[28], v[27], v[26], v[25:18], v[17:10], v[9:5], v[4:2], v[1:0]);
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_exp(input int d, input logic [29:0] v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic flush(input int d);
        if (d == 0) q0.delete();
        else        q1.delete();
    endtask

    // Reference model: enumerate every cycle of every pass from the sizing rules.
    task automatic push_tu(input int d, input int s, input bit inter);
        int nu, r, units, p, t, npass, j, x, y, ps;
        logic [2:0] od;
        logic [1:0] ci;
        nu    = 1 << (s - 2);
        r     = (d == 1) ? 2 * nu : nu;
        units = nu * r;
        p     = (!inter && units >= 16) ? units / 16 : 0;
        t     = p + units;
        npass = (d == 1) ? 2 : 1;
        for (int c = 0; c < npass; c++) begin
            ci = (d == 1) ? 2'(c + 1) : 2'd0;
            for (int k = 0; k < t; k++) begin
                if (k < p) begin
                    x = nu - 1; y = r - 1; ps = k;
                end else begin
                    j = k - p; x = nu - 1 - (j % nu); y = r - 1 - (j / nu); ps = 31;
                end
                if (k == t - 1)                 od = 3'd7;
                else if (k == t - 2 && t >= 3)  od = 3'd6;
                else if (k == t - 3 && t >= 4)  od = 3'd5;
                else if (k == 0)                od = 3'd0;
                else if (k == 1)                od = 3'd1;
                else                            od = 3'd2;
                push_exp(d, {4'b1100, 8'(x), 8'(y), 5'(ps), od, ci});
            end
        end
        push_exp(d, {4'b0010, 26'd0});
    endtask

    task automatic mon(input int d, input logic [29:0] act);
        logic [29:0] exp_v;
        int sz;
        sz    = qsize(d);
        exp_v = (sz == 0) ? 30'd0 : ((d == 0) ? q0[0] : q1[0]);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL scoreboard_dut%0d t=%0t: got {%s} required {%s}", d, $time, fmt(act), fmt(exp_v));
        end
        if (sz != 0 && !bStop) begin
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
    endtask

    // Monitor: compare every cycle; stalled cycles recheck the same entry.
    always @(negedge clk) begin
        mon(0, {w_ov0, w_busy0, w_dn0, w_er0, 8'(w_x0), 8'(w_y0), w_ps0, w_od0, w_ci0});
        mon(1, {w_ov1, w_busy1, w_dn1, w_er1, 8'(w_x1), 8'(w_y1), w_ps1, w_od1, w_ci1});
    end

    task automatic drain(input int d, input bit rnd);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 5000) begin
            bStop = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk); #2;
            n++;
        end
        bStop = 1'b0;
        n_checks++;
        if (qsize(d) != 0) begin
            n_errors++;
            $display("FAIL drain_dut%0d: %0d outputs pending after %0d cycles, required 0", d, qsize(d), n);
            flush(d);
        end
    endtask

    task automatic run_tu(input int d, input int s, input bit inter, input bit rnd);
        tuSize     = 3'(s);
        isInter    = inter;
        bStop      = 1'b0;
        start_v[d] = 1'b1;
        @(posedge clk); #2;
        start_v[d] = 1'b0;
        if (s >= 2 && s <= ((d == 0) ? 5 : 6)) push_tu(d, s, inter);
        else                                   push_exp(d, {4'b0001, 26'd0});
        drain(d, rnd);
    endtask

    initial begin
        int n, d, s;
        rst = 1'b1; bStop = 1'b0; isInter = 1'b0; tuSize = 3'd0; start_v = 2'b00;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;

        // Directed luma cases: 8x8, 32x32 intra/inter, 4x4, 16x16.
        run_tu(0, 3, 1'b0, 1'b0);
        run_tu(0, 5, 1'b0, 1'b0);
        run_tu(0, 5, 1'b1, 1'b0);
        run_tu(0, 2, 1'b0, 1'b0);
        run_tu(0, 4, 1'b0, 1'b0);
        // Directed chroma 4:2:2 cases.
        run_tu(1, 3, 1'b0, 1'b0);
        run_tu(1, 2, 1'b0, 1'b0);
        run_tu(1, 6, 1'b1, 1'b0);
        // Illegal sizes.
        run_tu(0, 6, 1'b0, 1'b0);
        run_tu(0, 7, 1'b0, 1'b0);
        run_tu(0, 1, 1'b0, 1'b0);
        run_tu(1, 7, 1'b0, 1'b0);

        // Stall of 5 cycles on unit (2,1) of a 16x16 intra pass.
        tuSize = 3'd4; isInter = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #2;
        start_v[0] = 1'b0;
        push_tu(0, 4, 1'b0);
        repeat (10) begin @(posedge clk); #2; end
        bStop = 1'b1;
        repeat (5) begin @(posedge clk); #2; end
        bStop = 1'b0;
        drain(0, 1'b0);

        // start while stalled in IDLE must be ignored.
        bStop = 1'b1; tuSize = 3'd3; start_v = 2'b11;
        @(posedge clk); #2;
        start_v = 2'b00;
        @(posedge clk); #2;
        bStop = 1'b0;
        repeat (3) begin @(posedge clk); #2; end

        // start held high through TU1 (ignored while busy) and across done.
        tuSize = 3'd3; isInter = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #2;
        push_tu(0, 3, 1'b0);
        tuSize = 3'd5; isInter = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!w_dn0 && n < 200);
        n_checks++;
        if (!w_dn0) begin
            n_errors++;
            $display("FAIL b2b_done_wait: done=%0b after %0d cycles, required 1", w_dn0, n);
        end
        @(posedge clk); #2;
        start_v[0] = 1'b0;
        push_tu(0, 5, 1'b1);
        drain(0, 1'b0);

        // Reset while unit (3,2) of a 16x16 intra pass is presented.
        tuSize = 3'd4; isInter = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #2;
        start_v[0] = 1'b0;
        push_tu(0, 4, 1'b0);
        repeat (5) begin @(posedge clk); #2; end
        rst = 1'b1;
        @(posedge clk); #2;
        flush(0); flush(1);
        rst = 1'b0;
        @(posedge clk); #2;
        run_tu(0, 4, 1'b0, 1'b0);

        // Randomized TUs with random stalls on both DUTs.
        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(0, 1));
            s = int'($urandom_range(1, 7));
            run_tu(d, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
